// File: rtl/data_lane_splitter.sv
// Two-lane skew generator: splits aligned word pairs into independent lanes, delaying the lagging lane.
// Optional SPLIT_STAT_EN adds a 16-bit wrapping counter of fully emitted pairs.
module data_lane_splitter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_SKEW = 8,
  parameter int unsigned SKEW_W   = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] data_1st_i,
  input  logic [DATA_W-1:0] data_2d_i,
  input  logic              vld_i,
  output logic              ready_o,
  input  logic [SKEW_W-1:0] skew_i,
  input  logic              lead_2d_i,
  output logic [DATA_W-1:0] data_1st_o,
  output logic              vld_1st_o,
  output logic [DATA_W-1:0] data_2d_o,
  output logic              vld_2d_o,
`ifdef SPLIT_STAT_EN
  output logic [15:0]       pairs_cnt_o,
`endif
  output logic [1:0]        statuses_o
);

  // In-flight count spans accept through the lagging output cycle, so it can reach MAX_SKEW+1.
  localparam int unsigned       CNT_W    = $clog2(MAX_SKEW + 2);
  localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(MAX_SKEW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic                cfg_lead;
  logic [SKEW_W-1:0]   cfg_skew;
  logic [SKEW_W-1:0]   skew_cl;
  logic                match;
  logic                accept;
  logic                lag_push;
  logic [DATA_W-1:0]   lag_in;
  logic [MAX_SKEW-1:0] lag_v;
  logic [DATA_W-1:0]   lag_d [MAX_SKEW];
  logic                tap_vld;
  logic [DATA_W-1:0]   tap_data;
  logic                rel_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                busy_q;
  logic                err_q;
  logic                l1_ld;
  logic                l2_ld;
  logic [DATA_W-1:0]   l1_d;
  logic [DATA_W-1:0]   l2_d;

  assign skew_cl  = (skew_i > SKEW_MAX) ? SKEW_MAX : skew_i;
  assign match    = (lead_2d_i == cfg_lead) && (skew_cl == cfg_skew);
  assign ready_o  = aresetn && ((state == IDLE) || ((state == RUN) && match));
  assign accept   = vld_i && ready_o;
  assign lag_push = accept && (skew_cl != '0);
  assign lag_in   = lead_2d_i ? data_1st_i : data_2d_i;
  assign cnt_nxt  = cnt + CNT_W'(lag_push) - CNT_W'(rel_q);
  assign statuses_o = {err_q, busy_q};

  // Tap the lag line at index cfg_skew-1; config is frozen while words are in flight.
  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int i = 0; i < int'(MAX_SKEW); i++) begin
      if (cfg_skew == SKEW_W'(i + 1)) begin
        tap_vld  = lag_v[i];
        tap_data = lag_d[i];
      end
    end
  end

  // Next lane loads: leading lane from the accepted beat, lagging lane from bypass or tap.
  always_comb begin
    l1_ld = 1'b0;
    l2_ld = 1'b0;
    l1_d  = data_1st_o;
    l2_d  = data_2d_o;
    if (accept) begin
      if (!lead_2d_i || (skew_cl == '0)) begin
        l1_ld = 1'b1;
        l1_d  = data_1st_i;
      end
      if (lead_2d_i || (skew_cl == '0)) begin
        l2_ld = 1'b1;
        l2_d  = data_2d_i;
      end
    end
    if (tap_vld) begin
      if (cfg_lead) begin
        l1_ld = 1'b1;
        l1_d  = tap_data;
      end else begin
        l2_ld = 1'b1;
        l2_d  = tap_data;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lag_v <= '0;
      for (int i = 0; i < int'(MAX_SKEW); i++) lag_d[i] <= '0;
    end else begin
      lag_v[0] <= lag_push;
      lag_d[0] <= lag_in;
      for (int i = 1; i < int'(MAX_SKEW); i++) begin
        lag_v[i] <= lag_v[i-1];
        lag_d[i] <= lag_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_1st_o  <= 1'b0;
      vld_2d_o   <= 1'b0;
      data_1st_o <= '0;
      data_2d_o  <= '0;
      rel_q      <= 1'b0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vld_1st_o <= l1_ld;
      vld_2d_o  <= l2_ld;
      if (l1_ld) data_1st_o <= l1_d;
      if (l2_ld) data_2d_o  <= l2_d;
      rel_q  <= tap_vld;
      cnt    <= cnt_nxt;
      busy_q <= (cnt_nxt != '0);
      err_q  <= err_q | (skew_i > SKEW_MAX);
    end
  end

  // Control FSM: config is latched on the first accept and only changes after a full drain.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      cfg_lead <= 1'b0;
      cfg_skew <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cfg_lead <= lead_2d_i;
            cfg_skew <= skew_cl;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!match)                       state <= DRAIN;
          else if (!vld_i && (cnt == '0))   state <= IDLE;
        end
        DRAIN: begin
          if (cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPLIT_STAT_EN
  logic pair_q;

  // Counts once per pair, in the cycle its lagging (or shared) lane valid is high.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pair_q      <= 1'b0;
      pairs_cnt_o <= '0;
    end else begin
      pair_q <= tap_vld || (accept && (skew_cl == '0));
      if (pair_q) pairs_cnt_o <= pairs_cnt_o + 16'd1;
    end
  end
`endif

endmodule
